bit_serial_alu: RTL and testbench



---
 rtl/bit_serial_alu.sv | 167 ++++++++++++++++
 tb/tb_bit_serial_alu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// Word ALU that reuses one single-bit slice, LSB first, over WIDTH cycles.
// Define BIT_SERIAL_ALU_FLAGS_EN to compute the overflow and zero flags; otherwise they read 0.
module bit_serial_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             invert,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic             inv_q, inv_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;

    logic             a_bit, b_eff, arith, sub;
    logic             slice_out, slice_cout, ov_raw;
    logic [WIDTH-1:0] word, final_res;

    always_comb begin
        arith = (sel_q == 3'd0) || (sel_q == 3'd6);
        sub   = ((sel_q == 3'd0) && inv_q) || (sel_q == 3'd6);
        a_bit = a_q[idx_q];
        b_eff = b_q[idx_q] ^ sub;

        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (sel_q)
            3'd0, 3'd6: begin
                slice_out  = a_bit ^ b_eff ^ carry_q;
                slice_cout = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
            end
            3'd1:    slice_out = a_bit & b_eff;
            3'd2:    slice_out = ~(a_bit & b_eff);
            3'd3:    slice_out = ~(a_bit | b_eff);
            3'd4:    slice_out = a_bit | b_eff;
            3'd5:    slice_out = a_bit ^ b_eff;
            default: slice_out = 1'b0;
        endcase

        word   = {slice_out, shift_q[WIDTH-1:1]};
        // On the MSB cycle carry_q is the carry into the MSB.
        ov_raw = carry_q ^ slice_cout;

        case (sel_q)
            3'd6:    final_res = {{(WIDTH-1){1'b0}}, slice_out ^ ov_raw};
            3'd7:    final_res = '0;
            default: final_res = word;
        endcase
    end

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    logic overflow_q, overflow_d, zero_q, zero_d;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        inv_d      = inv_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        shift_d    = shift_q;
        result_d   = result_q;
        carryout_d = carryout_q;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
        overflow_d = overflow_q;
        zero_d     = zero_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = sel;
                    inv_d   = invert;
                    idx_d   = '0;
                    carry_d = ((sel == 3'd0) && invert) || (sel == 3'd6);
                    state_d = StRun;
                end
            end
            StRun: begin
                shift_d = word;
                carry_d = slice_cout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(WIDTH - 1)) begin
                    state_d    = StDone;
                    result_d   = final_res;
                    carryout_d = arith & slice_cout;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
                    overflow_d = arith & ov_raw;
                    zero_d     = (final_res == '0);
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            inv_q      <= 1'b0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            shift_q    <= '0;
            result_q   <= '0;
            carryout_q <= 1'b0;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            inv_q      <= inv_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            shift_q    <= shift_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
`endif
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign carryout = carryout_q;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    assign overflow = overflow_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed self-checking bench for bit_serial_alu at WIDTH=8.
// Flag expectations follow BIT_SERIAL_ALU_FLAGS_EN the same way the design does.
module tb_bit_serial_alu;

    localparam int unsigned WIDTH = 8;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    localparam bit Flags = 1'b1;
`else
    localparam bit Flags = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, start, invert;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       sel;
    logic             ready, done, carryout, overflow, zero;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int fails  = 0;
    logic [WIDTH-1:0] prev_res;

    bit_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sel(sel), .invert(invert),
        .ready(ready), .done(done), .result(result), .carryout(carryout),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE and checks latency, held outputs during RUN and final values.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [2:0] tsel, input logic tinv, input logic [7:0] eres,
                          input logic ecout, input logic eov, input logic ezero);
        int lat;
        lat = 0;
        check({tag, " ready"}, ready, 1);
        a = ta; b = tb; sel = tsel; invert = tinv; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta; b = ~tb;
        for (int n = 1; n <= int'(WIDTH) + 4; n++) begin
            tick();
            if (n == 2) begin
                check({tag, " busy"}, ready, 0);
                check({tag, " held"}, result, prev_res);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, WIDTH);
        check({tag, " result"}, result, eres);
        check({tag, " cout"}, carryout, ecout);
        check({tag, " ovf"}, overflow, eov & Flags);
        check({tag, " zero"}, zero, ezero & Flags);
        tick();
        check({tag, " done_drop"}, {done, ready}, 2'b01);
        prev_res = eres;
    endtask

    initial begin
        int dones;
        logic [7:0] lres [5] = '{8'hC0, 8'h3F, 8'h03, 8'hFC, 8'h3C};
        reset = 1'b1; start = 1'b0; a = '0; b = '0; sel = '0; invert = 1'b0;
        prev_res = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst outs", {ready, done, carryout, overflow, zero}, 5'b10000);
        check("rst result", result, 8'h00);

        run_op("add 7f+01", 8'h7F, 8'h01, 3'd0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub 05-05", 8'h05, 8'h05, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub 03-05", 8'h03, 8'h05, 3'd0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);

        for (int s = 1; s <= 5; s++) begin
            for (int inv = 0; inv < 2; inv++) begin
                run_op($sformatf("logic sel%0d inv%0d", s, inv), 8'hF0, 8'hCC, 3'(s), 1'(inv),
                       lres[s-1], 1'b0, 1'b0, 1'b0);
            end
        end

        run_op("slt fe<03", 8'hFE, 8'h03, 3'd6, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op("slt 03<fe", 8'h03, 8'hFE, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("slt 80<7f", 8'h80, 8'h7F, 3'd6, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        run_op("rsvd sel7", 8'hAA, 8'h55, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Second start during RUN must be ignored.
        a = 8'h10; b = 8'h20; sel = 3'd0; invert = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 8'hFF; b = 8'hFF; sel = 3'd1; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                dones++;
                check("ignore start result", result, 8'h30);
            end
            tick();
        end
        check("ignore start one done", dones, 1);

        // Reset during RUN aborts without a done pulse.
        a = 8'h55; b = 8'h11; sel = 3'd0; invert = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort outs", {ready, done, carryout, overflow, zero}, 5'b10000);
        check("abort result", result, 8'h00);
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) dones++;
            tick();
        end
        check("abort no done", dones, 0);

        // Reset and start together: start is not accepted.
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst+start idle", ready, 1);
        tick();
        check("rst+start stays idle", ready, 1);

        prev_res = 8'h00;
        run_op("add 01+01", 8'h01, 8'h01, 3'd0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
